sdram_arb: RTL
==============

# sdram_arb

Two-port request arbiter in front of the `sdram` controller. It merges the CPU instruction-fetch port (32-bit reads) and data port (16-bit reads/writes) onto the controller's single request interface. It drives `instruction_mode` and completes each transaction against the controller's `c_cack`, `c_busy` and `c_read_ready` signals. It also provides a bus-hang timeout and an optional one-line instruction buffer.

## Interface
Parameters:
- `TIMEOUT`, default 1023: cycles allowed from request issue to completion before abort.

Ports:
- `clk` in 1: single clock; also drives the controller's `clk` and `srclk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request; level, held until `i_ready`.
- `i_addr` in 23: fetch address; stable while `i_req` is high.
- `i_ready` out 1: one-cycle completion pulse.
- `i_data` out 32: instruction word; valid while `i_ready` is high.
- `d_req` in 1: data request; level, held until `d_ready`.
- `d_we` in 1: 1 selects write.
- `d_imode` in 1: write into instruction space (program load).
- `d_addr` in 23: data address.
- `d_wdata` in 16: write data.
- `d_ready` out 1: one-cycle completion pulse.
- `d_rdata` out 16: read data; valid while `d_ready` is high.
- `err` out 1: one-cycle pulse on timeout abort.
- `m_addr` out 23 / `m_wdata` out 16: to `c_addr` / `c_data_in`.
- `m_read_req`, `m_write_req` out 1: to `c_read_req` / `c_write_req`.
- `m_imode` out 1: to `instruction_mode`.
- `m_rdata` in 32: from `c_data_out`.
- `m_busy`, `m_read_ready`, `m_cack` in 1: from the controller.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets state=IDLE, `last`=data, timeout counter=0 and line buffer invalid.
- States:
  - IDLE
    - Arbitration is round-robin. If exactly one of `i_req`/`d_req` is high, that port wins. If both are high, the port not recorded in `last` wins.
    - IDLE latches the address, write data, direction and mode into internal registers, drives the `m_*` outputs from them, asserts the chosen `m_*_req`, loads the counter with `TIMEOUT` and moves to REQ.
    - `m_imode` is 1 for fetches and equals `d_imode` for data transactions.
  - REQ
    - Holds the request until `m_cack`=1, then drops it.
    - Reads go to RD_LO. Writes go to WR_HI.
  - RD_LO: waits for `m_read_ready`=0, which clears stale ready from the previous read, then goes to RD_HI.
  - RD_HI
    - Waits for `m_read_ready`=1. It then pulses the granted ready and goes to IDLE.
    - `i_data` = `m_rdata[31:0]`. `d_rdata` = `m_rdata[15:0]`.
  - WR_HI: waits for `m_busy`=1, then goes to WR_LO.
  - WR_LO: waits for `m_busy`=0, then pulses `d_ready` and goes to IDLE.
- `m_addr`, `m_wdata` and `m_imode` stay stable from IDLE exit until return to IDLE.
- `last` updates to the granted port at completion.
- Timeout
  - The counter decrements every cycle outside IDLE.
  - On reaching 0 in any non-IDLE state, the block does all of the following in one cycle:
    - drops `m_*_req`;
    - pulses `err` and the granted ready, with data 0;
    - returns to IDLE.
  - The line buffer is not updated on a timeout.
- Ready is ignored in the cycle of the pulse. If the requester keeps `req` high in the next IDLE cycle, that is treated as a new request.

## Timing
- Arbitration: one cycle from `req` in IDLE to `m_*_req` high.
- Best-case read: IDLE→REQ (1) + cack wait + controller latency + 1 cycle output register.
- `m_*_req` never rises while `m_busy`=1 is sampled in IDLE. IDLE stalls instead.
- `d_req` and `i_req` that both rise in the same IDLE cycle at reset: fetch wins first (`last`=data).
- Reset assertion mid-transaction aborts immediately: requests drop asynchronously and no ready pulse is issued.

## Configuration
- `SDRAM_ARB_ILINE_EN` defined:
  - Adds a one-entry buffer holding the tag (23 b) and data (32 b) of the last completed fetch.
  - An `i_req` in IDLE whose address matches a valid tag pulses `i_ready` with the buffered data one cycle later. No SDRAM access is made and `last` is unchanged. A pending `d_req` in the same cycle still wins arbitration first if `last`=fetch.
  - Any completed write with `d_imode`=1 invalidates the buffer, as does a timeout during a fetch.
- Undefined: every fetch goes to SDRAM.

## Test plan
- Reset, then a data read with `d_addr`=0x000123:
  - `m_read_req`=1 and `m_imode`=0 one cycle after `d_req`;
  - model returns `m_rdata`=0x0000BEEF → one `d_ready` pulse with `d_rdata`=0xBEEF;
  - `err`=0.
- Fetch with `i_addr`=0x000040, model returns 0x12345678 → `i_ready` pulse with `i_data`=0x12345678 and `m_imode`=1 throughout.
- Both `i_req` and `d_req` held high for 4 transactions → grants alternate I,D,I,D and no port is starved.
- Data write with 0x00AA to 0x000010, where the model holds `m_busy` high for 5 cycles after `m_cack` → `d_ready` comes exactly 1 cycle after `m_busy` falls, and `m_wdata`=0x00AA stays stable throughout.
- `TIMEOUT`=8 with a model that never asserts cack → `err` and `i_ready` pulse together 8 cycles after issue with `i_data`=0; the next request proceeds normally.
- With `SDRAM_ARB_ILINE_EN`:
  - repeated fetch of 0x000040 → second `i_ready` 1 cycle after `i_req`, with no `m_read_req`;
  - after a `d_imode`=1 write, the same fetch reaches SDRAM again.

Source files
------------

// File: rtl/sdram_arb.sv
// sdram_arb: two-port round-robin arbiter in front of the sdram controller.
//
// Merges the CPU instruction-fetch port (32-bit reads) and the data port
// (16-bit reads/writes) onto the controller's single request interface.
// Every output is registered and resets to 0.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   i_req/i_addr        fetch request (level) and 23-bit address
//   i_ready/i_data      one-cycle fetch completion pulse and 32-bit word
//   d_req/d_we/d_imode  data request, write select, instruction-space write
//   d_addr/d_wdata      23-bit data address, 16-bit write data
//   d_ready/d_rdata     one-cycle data completion pulse and 16-bit read data
//   err                 one-cycle pulse on timeout abort
//   m_addr/m_wdata      to controller c_addr / c_data_in
//   m_read_req/m_write_req/m_imode  to c_read_req / c_write_req / instruction_mode
//   m_rdata             from c_data_out
//   m_busy/m_read_ready/m_cack      controller status
//
// Parameter TIMEOUT: cycles allowed from request issue to completion.
// Optional feature macro SDRAM_ARB_ILINE_EN: one-line instruction buffer.

module sdram_arb #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [22:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_imode,
  input  logic [22:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic        err,
  output logic [22:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_read_req,
  output logic        m_write_req,
  output logic        m_imode,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  input  logic        m_read_ready,
  input  logic        m_cack
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, RD_LO, RD_HI, WR_HI, WR_LO} state_t;
  typedef enum logic {PORT_D, PORT_I} port_t;

  state_t          state, state_n;
  port_t           last, last_n;
  port_t           gnt, gnt_n;
  logic            we, we_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic [22:0]     m_addr_n;
  logic [15:0]     m_wdata_n;
  logic            m_read_req_n, m_write_req_n, m_imode_n;
  logic            i_ready_n, d_ready_n, err_n;
  logic [31:0]     i_data_n;
  logic [15:0]     d_rdata_n;

  logic            i_act, d_act, pick_fetch, pick_data, tmo;
  logic            lb_hit;
  logic [31:0]     lb_data;

  // A port whose ready is pulsing this cycle is not re-arbitrated yet.
  assign i_act = i_req & ~i_ready;
  assign d_act = d_req & ~d_ready;
  assign pick_fetch = i_act & (~d_act | (last == PORT_D));
  assign pick_data  = d_act & (~i_act | (last == PORT_I));

  // The counter hits 0 on the same edge that performs the abort.
  assign tmo = (state != IDLE) && (cnt <= CW'(1));

`ifdef SDRAM_ARB_ILINE_EN
  logic            lb_valid;
  logic [22:0]     lb_tag;
  logic            lb_fill, lb_inval;

  assign lb_hit   = lb_valid && (lb_tag == i_addr);
  assign lb_fill  = (state == RD_HI) && m_read_ready && (gnt == PORT_I) && !tmo;
  assign lb_inval = ((state == WR_LO) && !m_busy && m_imode && !tmo) ||
                    (tmo && (gnt == PORT_I));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_valid <= 1'b0;
      lb_tag   <= '0;
      lb_data  <= '0;
    end else if (lb_fill) begin
      lb_valid <= 1'b1;
      lb_tag   <= m_addr;
      lb_data  <= m_rdata;
    end else if (lb_inval) begin
      lb_valid <= 1'b0;
    end
  end
`else
  assign lb_hit  = 1'b0;
  assign lb_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= PORT_D;
      gnt         <= PORT_D;
      we          <= 1'b0;
      cnt         <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_read_req  <= 1'b0;
      m_write_req <= 1'b0;
      m_imode     <= 1'b0;
      i_ready     <= 1'b0;
      i_data      <= '0;
      d_ready     <= 1'b0;
      d_rdata     <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      last        <= last_n;
      gnt         <= gnt_n;
      we          <= we_n;
      cnt         <= cnt_n;
      m_addr      <= m_addr_n;
      m_wdata     <= m_wdata_n;
      m_read_req  <= m_read_req_n;
      m_write_req <= m_write_req_n;
      m_imode     <= m_imode_n;
      i_ready     <= i_ready_n;
      i_data      <= i_data_n;
      d_ready     <= d_ready_n;
      d_rdata     <= d_rdata_n;
      err         <= err_n;
    end
  end

  always_comb begin
    state_n       = state;
    last_n        = last;
    gnt_n         = gnt;
    we_n          = we;
    cnt_n         = (state != IDLE) ? cnt - CW'(1) : cnt;
    m_addr_n      = m_addr;
    m_wdata_n     = m_wdata;
    m_read_req_n  = m_read_req;
    m_write_req_n = m_write_req;
    m_imode_n     = m_imode;
    i_ready_n     = 1'b0;
    i_data_n      = i_data;
    d_ready_n     = 1'b0;
    d_rdata_n     = d_rdata;
    err_n         = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_fetch && lb_hit) begin
          // Buffered line: answer locally, arbitration history untouched.
          i_ready_n = 1'b1;
          i_data_n  = lb_data;
        end else if (!m_busy && (pick_fetch || pick_data)) begin
          gnt_n         = pick_fetch ? PORT_I : PORT_D;
          we_n          = pick_data & d_we;
          m_addr_n      = pick_fetch ? i_addr : d_addr;
          m_wdata_n     = pick_fetch ? m_wdata : d_wdata;
          m_imode_n     = pick_fetch | d_imode;
          m_read_req_n  = ~(pick_data & d_we);
          m_write_req_n = pick_data & d_we;
          cnt_n         = CW'(TIMEOUT);
          state_n       = REQ;
        end
      end
      REQ: begin
        if (m_cack) begin
          m_read_req_n  = 1'b0;
          m_write_req_n = 1'b0;
          state_n       = we ? WR_HI : RD_LO;
        end
      end
      RD_LO: begin
        if (!m_read_ready) state_n = RD_HI;
      end
      RD_HI: begin
        if (m_read_ready) begin
          if (gnt == PORT_I) begin
            i_ready_n = 1'b1;
            i_data_n  = m_rdata;
          end else begin
            d_ready_n = 1'b1;
            d_rdata_n = m_rdata[15:0];
          end
          last_n  = gnt;
          state_n = IDLE;
        end
      end
      WR_HI: begin
        if (m_busy) state_n = WR_LO;
      end
      WR_LO: begin
        if (!m_busy) begin
          d_ready_n = 1'b1;
          last_n    = gnt;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Timeout overrides whatever the state logic decided this cycle.
    if (tmo) begin
      m_read_req_n  = 1'b0;
      m_write_req_n = 1'b0;
      err_n         = 1'b1;
      if (gnt == PORT_I) begin
        i_ready_n = 1'b1;
        i_data_n  = '0;
        d_ready_n = 1'b0;
      end else begin
        d_ready_n = 1'b1;
        d_rdata_n = '0;
        i_ready_n = 1'b0;
      end
      last_n  = gnt;
      state_n = IDLE;
    end
  end

endmodule
